// File: rtl/gr_col_scheduler.sv
// Double-buffered frame store and column-burst issue sequencer feeding the GR QR array.
// Optional statistics (o_frame_cnt, o_stall_cnt) are built when GR_SCHED_STAT_EN is defined.
module gr_col_scheduler #(
    parameter int INOUT_WIDTH = 16,
    parameter int N_ROW       = 4,
    parameter int N_COL       = 5,
    parameter int GAP_CYC     = 10
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_in_valid,
    input  logic [2*INOUT_WIDTH-1:0]   i_in_data,
    output logic                       o_in_ready,
    output logic                       o_gr_valid,
    output logic [2*INOUT_WIDTH-1:0]   o_gr_data,
    output logic                       o_gr_first,
    output logic                       o_gr_last,
    output logic [$clog2(N_COL)-1:0]   o_col_idx,
`ifdef GR_SCHED_STAT_EN
    output logic [15:0]                o_frame_cnt,
    output logic [15:0]                o_stall_cnt,
`endif
    output logic                       o_frame_done
);

    localparam int DW    = 2 * INOUT_WIDTH;
    localparam int DEPTH = N_ROW * N_COL;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int CW    = $clog2(N_COL);
    localparam int GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(N_ROW - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(N_COL - 1);
    localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          st_r, st_nxt_s;
    logic [RW-1:0]   row_r, row_nxt_s;
    logic [CW-1:0]   col_r, col_nxt_s;
    logic [GW-1:0]   gap_r, gap_nxt_s;
    logic            wr_bank_r, rd_bank_r;
    logic [AW-1:0]   wr_cnt_r;
    logic [1:0]      full_r, full_nxt_s;
    logic            wr_fire_s, wr_fill_s, rd_clear_s;
    logic [AW-1:0]   rd_addr_s;
    logic [DW-1:0]   mem_r [2][DEPTH];

    assign o_in_ready = !full_r[wr_bank_r];
    assign wr_fire_s  = i_in_valid && o_in_ready;
    assign wr_fill_s  = wr_fire_s && (wr_cnt_r == LAST_ADDR);
    assign rd_clear_s = (st_r == S_DONE);
    assign rd_addr_s  = AW'((32'(col_nxt_s) * 32'(N_ROW)) + 32'(row_nxt_s));

    // Sample storage: written only while the target bank is not full, so no reset needed
    always_ff @(posedge i_clk) begin
        if (wr_fire_s) begin
            mem_r[wr_bank_r][wr_cnt_r] <= i_in_data;
        end
    end

    // Per-bank full flags: fill and drain can hit different banks in the same cycle
    always_comb begin
        full_nxt_s = full_r;
        for (int b = 0; b < 2; b++) begin
            if (wr_fill_s && (wr_bank_r == 1'(b))) begin
                full_nxt_s[b] = 1'b1;
            end else if (rd_clear_s && (rd_bank_r == 1'(b))) begin
                full_nxt_s[b] = 1'b0;
            end else begin
                full_nxt_s[b] = full_r[b];
            end
        end
    end

    // Write pointer, bank selects and full flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_cnt_r  <= {AW{1'b0}};
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            full_r    <= 2'b00;
        end else begin
            full_r <= full_nxt_s;
            if (wr_fill_s) begin
                wr_cnt_r  <= {AW{1'b0}};
                wr_bank_r <= ~wr_bank_r;
            end else if (wr_fire_s) begin
                wr_cnt_r  <= wr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_cnt_r  <= wr_cnt_r;
            end
            if (rd_clear_s) begin
                rd_bank_r <= ~rd_bank_r;
            end else begin
                rd_bank_r <= rd_bank_r;
            end
        end
    end

    // Read-side next state and issue position
    always_comb begin
        st_nxt_s  = st_r;
        row_nxt_s = row_r;
        col_nxt_s = col_r;
        gap_nxt_s = gap_r;
        case (st_r)
            S_IDLE: begin
                if (full_r[rd_bank_r]) begin
                    st_nxt_s  = S_ISSUE;
                    row_nxt_s = {RW{1'b0}};
                    col_nxt_s = {CW{1'b0}};
                end else begin
                    st_nxt_s  = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (row_r == LAST_ROW) begin
                    if (col_r == LAST_COL) begin
                        st_nxt_s  = S_DONE;
                    end else begin
                        st_nxt_s  = S_GAP;
                        gap_nxt_s = {GW{1'b0}};
                    end
                end else begin
                    row_nxt_s = row_r + {{(RW-1){1'b0}}, 1'b1};
                end
            end
            S_GAP: begin
                if (gap_r == LAST_GAP) begin
                    st_nxt_s  = S_ISSUE;
                    row_nxt_s = {RW{1'b0}};
                    col_nxt_s = col_r + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    gap_nxt_s = gap_r + {{(GW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                st_nxt_s = S_IDLE;
            end
            default: begin
                st_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register; it always describes what the output registers currently show
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_r  <= S_IDLE;
            row_r <= {RW{1'b0}};
            col_r <= {CW{1'b0}};
            gap_r <= {GW{1'b0}};
        end else begin
            st_r  <= st_nxt_s;
            row_r <= row_nxt_s;
            col_r <= col_nxt_s;
            gap_r <= gap_nxt_s;
        end
    end

    // Issue registers load from the upcoming position so the first sample follows IDLE directly
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_gr_valid   <= 1'b0;
            o_gr_data    <= {DW{1'b0}};
            o_gr_first   <= 1'b0;
            o_gr_last    <= 1'b0;
            o_col_idx    <= {CW{1'b0}};
            o_frame_done <= 1'b0;
        end else begin
            o_gr_valid   <= (st_nxt_s == S_ISSUE);
            o_frame_done <= (st_nxt_s == S_DONE);
            if (st_nxt_s == S_ISSUE) begin
                o_gr_data  <= mem_r[rd_bank_r][rd_addr_s];
                o_gr_first <= (row_nxt_s == {RW{1'b0}});
                o_gr_last  <= (row_nxt_s == LAST_ROW);
                o_col_idx  <= col_nxt_s;
            end else begin
                o_gr_data  <= o_gr_data;
                o_gr_first <= o_gr_first;
                o_gr_last  <= o_gr_last;
                o_col_idx  <= o_col_idx;
            end
        end
    end

`ifdef GR_SCHED_STAT_EN
    logic [15:0] frame_cnt_r, stall_cnt_r;

    assign o_frame_cnt = frame_cnt_r;
    assign o_stall_cnt = stall_cnt_r;

    // Frame counter wraps; stall counter saturates
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt_r <= 16'd0;
            stall_cnt_r <= 16'd0;
        end else begin
            if (o_frame_done) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            if (i_in_valid && !o_in_ready && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gr_col_scheduler.sv
// Self-checking bench for gr_col_scheduler: random stimulus against a frame-level timing model.
`timescale 1ns/1ps
module tb_gr_col_scheduler;

    localparam int NR   = 4;
    localparam int NC   = 5;
    localparam int GAP  = 10;
    localparam int FR   = NR * NC;
    localparam int SPAN = FR + (NC - 1) * GAP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready, gr_valid, gr_first, gr_last, frame_done;
    logic [31:0] gr_data;
    logic [2:0]  col_idx;
`ifdef GR_SCHED_STAT_EN
    logic [15:0] frame_cnt, stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  col;
        logic        first;
        logic        last;
        logic [31:0] data;
    } ev_t;

    ev_t obs_q[$];
    ev_t ex_q[$];
    int  done_q[$];
    int  ex_done_q[$];
    int  g_t[$];
    int  ready_bad, ready_bad_cyc, g_stall;
    bit  timed_out;

    gr_col_scheduler #(.INOUT_WIDTH(16), .N_ROW(NR), .N_COL(NC), .GAP_CYC(GAP)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_gr_valid   (gr_valid),
        .o_gr_data    (gr_data),
        .o_gr_first   (gr_first),
        .o_gr_last    (gr_last),
        .o_col_idx    (col_idx),
`ifdef GR_SCHED_STAT_EN
        .o_frame_cnt  (frame_cnt),
        .o_stall_cnt  (stall_cnt),
`endif
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (gr_valid) begin
                e.cyc = cyc; e.col = col_idx; e.first = gr_first; e.last = gr_last; e.data = gr_data;
                obs_q.push_back(e);
            end
            if (frame_done) done_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        done_q.delete();
        @(negedge clk);
    endtask

    // Stimulus plus reference model: a frame's bank is full from its last accept until
    // the cycle after its done pulse; a frame starts the cycle after full, or two cycles
    // after the previous frame's done, whichever is later.
    task automatic run_frames(input int nfr, input int pct, input logic [15:0] base, input bit rnd_im);
        logic [31:0] buf_q[$];
        int sent, last_d, budget, live, t_acc, s_start;
        bit v, rdy_e;
        ev_t e;
        sent = 0; last_d = -1000; budget = nfr * 300 + 100;
        ex_q.delete(); ex_done_q.delete(); g_t.delete();
        ready_bad = 0; ready_bad_cyc = 0; g_stall = 0;
        while ((sent < nfr * FR || cyc <= last_d + 2) && budget > 0) begin
            live = 0;
            foreach (ex_done_q[i]) if (cyc <= ex_done_q[i]) live++;
            rdy_e = (live < 2);
            if (in_ready !== rdy_e) begin
                if (ready_bad == 0) ready_bad_cyc = cyc;
                ready_bad++;
            end
            v = (sent < nfr * FR) && ($urandom_range(99) < pct);
            in_valid = v;
            in_data  = {(rnd_im ? 16'($urandom) : 16'd0), base + 16'(sent)};
            if (v && !rdy_e) g_stall++;
            if (v && rdy_e) begin
                buf_q.push_back(in_data);
                sent++;
                if (buf_q.size() == FR) begin
                    t_acc = cyc + 1;
                    g_t.push_back(t_acc);
                    s_start = (t_acc + 1 > last_d + 2) ? t_acc + 1 : last_d + 2;
                    for (int j = 0; j < FR; j++) begin
                        e.cyc   = s_start + (j / NR) * (NR + GAP) + (j % NR);
                        e.col   = 3'(j / NR);
                        e.first = (j % NR == 0);
                        e.last  = (j % NR == NR - 1);
                        e.data  = buf_q[j];
                        ex_q.push_back(e);
                    end
                    last_d = s_start + SPAN;
                    ex_done_q.push_back(last_d);
                    buf_q.delete();
                end
            end
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        timed_out = (budget <= 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++; if (gr_valid !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b want=0", gr_valid); end
        total++; if (gr_data !== 32'd0)    begin bad++; $display("FAIL reset_data got=%h want=0", gr_data); end
        total++; if (gr_first !== 1'b0)    begin bad++; $display("FAIL reset_first got=%b want=0", gr_first); end
        total++; if (gr_last !== 1'b0)     begin bad++; $display("FAIL reset_last got=%b want=0", gr_last); end
        total++; if (col_idx !== 3'd0)     begin bad++; $display("FAIL reset_col got=%0d want=0", col_idx); end
        total++; if (frame_done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
`ifdef GR_SCHED_STAT_EN
        total++; if (frame_cnt !== 16'd0)  begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
        total++; if (stall_cnt !== 16'd0)  begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
`endif
        do_reset();
    endtask

    task automatic test_single_frame();
        do_reset();
        run_frames(1, 100, 16'd0, 1'b0);
        total++; if (timed_out)            begin bad++; $display("FAIL t1_timeout got=1 want=0"); end
        total++; if (ready_bad !== 0)      begin bad++; $display("FAIL t1_ready got=%0d_bad_cycles(first@%0d) want=0", ready_bad, ready_bad_cyc); end
        total++; if (obs_q.size() !== ex_q.size()) begin bad++; $display("FAIL t1_count got=%0d want=%0d", obs_q.size(), ex_q.size()); end
        for (int i = 0; i < ex_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== ex_q[i]) begin
                bad++;
                $display("FAIL t1_sample[%0d] got cyc=%0d d=%h f=%b l=%b c=%0d want cyc=%0d d=%h f=%b l=%b c=%0d", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].col,
                         ex_q[i].cyc, ex_q[i].data, ex_q[i].first, ex_q[i].last, ex_q[i].col);
            end
        end
        total++; if (done_q.size() !== 1)  begin bad++; $display("FAIL t1_done_count got=%0d want=1", done_q.size()); end
        if (done_q.size() > 0) begin
            total++; if (done_q[0] !== ex_done_q[0]) begin bad++; $display("FAIL t1_done_cyc got=%0d want=%0d", done_q[0], ex_done_q[0]); end
        end
    endtask

    task automatic test_latency();
        total++;
        if (obs_q.size() == 0 || g_t.size() == 0) begin
            bad++; $display("FAIL t2_latency got=no_output want=first_valid");
        end else if (obs_q[0].cyc - g_t[0] !== 1) begin
            bad++; $display("FAIL t2_latency got=%0d want=1", obs_q[0].cyc - g_t[0]);
        end
        total++;
        if (obs_q.size() == 0 || done_q.size() == 0) begin
            bad++; $display("FAIL t2_span got=no_done want=%0d", SPAN);
        end else if (done_q[0] - obs_q[0].cyc !== SPAN) begin
            bad++; $display("FAIL t2_span got=%0d want=%0d", done_q[0] - obs_q[0].cyc, SPAN);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_frames(3, 100, 16'd100, 1'b1);
        total++; if (timed_out)            begin bad++; $display("FAIL t3_timeout got=1 want=0"); end
        total++; if (ready_bad !== 0)      begin bad++; $display("FAIL t3_ready got=%0d_bad_cycles(first@%0d) want=0", ready_bad, ready_bad_cyc); end
        total++; if (obs_q.size() !== ex_q.size()) begin bad++; $display("FAIL t3_count got=%0d want=%0d", obs_q.size(), ex_q.size()); end
        for (int i = 0; i < ex_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== ex_q[i]) begin
                bad++;
                $display("FAIL t3_sample[%0d] got cyc=%0d d=%h f=%b l=%b c=%0d want cyc=%0d d=%h f=%b l=%b c=%0d", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].col,
                         ex_q[i].cyc, ex_q[i].data, ex_q[i].first, ex_q[i].last, ex_q[i].col);
            end
        end
        total++; if (done_q.size() !== 3)  begin bad++; $display("FAIL t3_done_count got=%0d want=3", done_q.size()); end
        for (int i = 0; i < done_q.size() && i < ex_done_q.size(); i++) begin
            total++; if (done_q[i] !== ex_done_q[i]) begin bad++; $display("FAIL t3_done_cyc[%0d] got=%0d want=%0d", i, done_q[i], ex_done_q[i]); end
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        run_frames(2, 50, 16'd300, 1'b1);
        total++; if (timed_out)            begin bad++; $display("FAIL t4_timeout got=1 want=0"); end
        total++; if (ready_bad !== 0)      begin bad++; $display("FAIL t4_ready got=%0d_bad_cycles(first@%0d) want=0", ready_bad, ready_bad_cyc); end
        total++; if (obs_q.size() !== ex_q.size()) begin bad++; $display("FAIL t4_count got=%0d want=%0d", obs_q.size(), ex_q.size()); end
        for (int i = 0; i < ex_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== ex_q[i]) begin
                bad++;
                $display("FAIL t4_sample[%0d] got cyc=%0d d=%h f=%b l=%b c=%0d want cyc=%0d d=%h f=%b l=%b c=%0d", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].col,
                         ex_q[i].cyc, ex_q[i].data, ex_q[i].first, ex_q[i].last, ex_q[i].col);
            end
        end
        total++; if (done_q.size() !== 2)  begin bad++; $display("FAIL t4_done_count got=%0d want=2", done_q.size()); end
    endtask

    task automatic test_reset_mid();
        int t_last, guard;
        do_reset();
        t_last = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            in_valid = 1'b1;
            in_data  = {16'hA5A5, 16'(200 + i)};
            if (i == FR - 1) t_last = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        guard = 0;
        while (cyc < t_last + 30 && guard < 200) begin @(negedge clk); guard++; end
        total++; if (gr_valid !== 1'b1 || gr_data !== {16'hA5A5, 16'd209} || col_idx !== 3'd2) begin
            bad++; $display("FAIL t5_pre_reset got v=%b d=%h c=%0d want v=1 d=a5a500d1 c=2", gr_valid, gr_data, col_idx);
        end
        rst = 1'b1;
        #1;
        total++; if (gr_valid !== 1'b0)    begin bad++; $display("FAIL t5_valid got=%b want=0", gr_valid); end
        total++; if (gr_data !== 32'd0)    begin bad++; $display("FAIL t5_data got=%h want=0", gr_data); end
        total++; if (gr_first !== 1'b0 || gr_last !== 1'b0) begin bad++; $display("FAIL t5_flags got=%b%b want=00", gr_first, gr_last); end
        total++; if (col_idx !== 3'd0)     begin bad++; $display("FAIL t5_col got=%0d want=0", col_idx); end
        total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL t5_ready got=%b want=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        done_q.delete();
        run_frames(1, 100, 16'd600, 1'b1);
        total++; if (timed_out)            begin bad++; $display("FAIL t5_timeout got=1 want=0"); end
        total++; if (obs_q.size() !== ex_q.size()) begin bad++; $display("FAIL t5_count got=%0d want=%0d", obs_q.size(), ex_q.size()); end
        for (int i = 0; i < ex_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== ex_q[i]) begin
                bad++;
                $display("FAIL t5_sample[%0d] got cyc=%0d d=%h c=%0d want cyc=%0d d=%h c=%0d", i,
                         obs_q[i].cyc, obs_q[i].data, obs_q[i].col, ex_q[i].cyc, ex_q[i].data, ex_q[i].col);
            end
        end
        total++; if (done_q.size() !== 1)  begin bad++; $display("FAIL t5_done_count got=%0d want=1", done_q.size()); end
    endtask

`ifdef GR_SCHED_STAT_EN
    task automatic test_stats();
        do_reset();
        run_frames(3, 100, 16'd800, 1'b0);
        total++; if (frame_cnt !== 16'd3)  begin bad++; $display("FAIL t6_frame_cnt got=%0d want=3", frame_cnt); end
        total++; if (stall_cnt !== 16'(g_stall)) begin bad++; $display("FAIL t6_stall_cnt got=%0d want=%0d", stall_cnt, g_stall); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_latency();
        test_back_to_back();
        test_bubbles();
        test_reset_mid();
`ifdef GR_SCHED_STAT_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
